spi_master_param: RTL and testbench
===================================

Name: spi_master_param

Overview:
- Parametrised successor to the fixed 15-bit SPI master.
- Full-duplex SPI master with:
  - configurable frame width and SCLK divider;
  - runtime-selectable SPI mode (CPOL/CPHA) and bit order;
  - N one-hot active-low slave selects;
  - abort input and done/busy handshake.
- Sits between a local controller and one or more SPI slaves. Drives the existing slave via LOAD/SCLK/MOSI/MISO.

Parameters:
- W, 15, frame width in bits (W >= 2).
- DIV, 4, clk cycles per SCLK half-period (DIV >= 1).
- N_SS, 4, number of slave-select lines (1..2^SSW).
- SSW, 2, width of ss_sel.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- clr  in  1  asynchronous, active-low reset.
- st  in  1  start request.
- abort  in  1  synchronous abort of the current frame.
- mode  in  2  {CPOL,CPHA}, latched at start.
- lsb_first  in  1  1 = LSB shifted first; latched at start.
- ss_sel  in  SSW  slave index; latched at start.
- DI  in  W  transmit word; latched at start.
- MISO  in  1  serial data from slave.
- DO  out  W  last completed received word.
- busy  out  1  frame in progress.
- done  out  1  one-cycle completion pulse.
- LOAD  out  1  frame envelope; high in LEAD, XFER and TRAIL.
- SCLK  out  1  serial clock.
- MOSI  out  1  serial data to slave.
- SS_N  out  N_SS  active-low slave selects, at most one low.

Behaviour:
- **Reset** (clr = 0, asynchronous):
  - State IDLE.
  - DO = 0, busy = 0, done = 0, LOAD = 0.
  - SCLK = 0, MOSI = 0, SS_N = all 1.
  - Shift registers and counters cleared.
  - Reset mid-frame aborts immediately, with no done pulse.
- **IDLE**:
  - SCLK = latched CPOL (0 after reset), SS_N all 1, busy = 0.
  - If st = 1 at a rising edge: latch DI, mode, lsb_first, ss_sel; go to LEAD.
- **LEAD** (DIV cycles):
  - busy = 1, LOAD = 1, SS_N[ss_sel] = 0.
  - If ss_sel >= N_SS, all SS_N stay 1 but the frame still runs.
  - CPHA = 0: MOSI presents the first bit on entry.
- **XFER** (2W half-periods, DIV cycles each):
  - SCLK toggles at the end of each half-period. Edge count e = 1..2W.
  - CPHA = 0: odd e samples MISO; even e < 2W shifts out the next bit.
  - CPHA = 1: odd e shifts out a bit (e = 1 presents the first bit); even e samples MISO.
  - After edge 2W, SCLK = CPOL.
- **Bit order**:
  - lsb_first = 0: transmit DI[W-1] first; receive shifts in at the LSB.
  - lsb_first = 1: transmit DI[0] first; receive fills from the MSB side, so DO[0] is the first bit received.
- **TRAIL** (DIV cycles): SS_N held low, SCLK = CPOL, MOSI held.
- **DONE** (1 cycle):
  - SS_N all 1, LOAD = 0, done = 1, busy = 0.
  - DO updated with the received word and valid from this cycle. DO is held until the next DONE.
  - st = 1 in DONE starts the next frame (next state LEAD). SS_N is high for exactly 1 cycle between back-to-back frames.
  - Otherwise go to IDLE.
- **Latency**: st sampled at edge 0 → done high in cycle 1 + (2W+2)·DIV.
- **Ignored inputs**:
  - st while busy is ignored.
  - DI, mode, lsb_first and ss_sel changes mid-frame have no effect.
- **abort** (in LEAD, XFER or TRAIL):
  - Next cycle: IDLE, SS_N all 1, SCLK = CPOL, LOAD = 0.
  - No done pulse; DO unchanged.
  - abort in IDLE or DONE has no effect.
  - abort and st both high in IDLE: start wins.
- **Timing and glitches**:
  - All outputs registered and glitch-free.
  - SCLK high and low phases are each exactly DIV cycles.

Test Plan:
- Loopback (MOSI→MISO), W=15, DIV=2, mode 0, MSB first, DI=15'h5A3C, ss_sel=1:
  - DO=15'h5A3C and done pulse at cycle 1+32·2=65.
  - SS_N=4'b1101 during LEAD through TRAIL; SCLK idle 0.
- All four modes with slave model returning 15'h1234, DI=15'h7FFF:
  - DO=15'h1234 in each mode.
  - SCLK idle level equals CPOL.
  - MOSI changes only on the non-sampling edge.
- lsb_first=1, DI=15'h0001:
  - MOSI=1 during the first bit, 0 for the remaining 14 bits.
  - Loopback DO=15'h0001.
- Back-to-back: st held high, DI=15'h0AAA then 15'h1555:
  - Two done pulses 1+32·DIV cycles apart.
  - SS_N high for exactly 1 cycle between frames.
- Abort after edge 10 with DO previously 15'h0F0F:
  - Next cycle busy=0, SS_N=all 1, no done pulse, DO=15'h0F0F.
- clr=0 asserted mid-XFER:
  - Immediately all outputs at reset values.
  - After release, a new st completes a normal frame.

Source files
------------

// File: rtl/spi_master_param.sv
// rtl/spi_master_param.sv - parametrised full-duplex SPI master
//
// Purpose: shifts one W-bit frame out on MOSI while sampling MISO, with
// runtime-selectable SPI mode and bit order, one-hot active-low slave selects,
// abort, and a done/busy handshake. Every output comes straight from a flop.
//
// Ports:
//   clk        system clock, rising edge
//   clr        asynchronous active-low reset
//   st         start request (ignored while busy)
//   abort      drop the running frame (LEAD/XFER/TRAIL only)
//   mode       {CPOL,CPHA}, latched at start
//   lsb_first  1 = LSB shifted first, latched at start
//   ss_sel     slave index, latched at start
//   DI         transmit word, latched at start
//   MISO       serial data from slave
//   DO         last completed received word
//   busy       frame in progress
//   done       one-cycle completion pulse
//   LOAD       frame envelope (LEAD, XFER, TRAIL)
//   SCLK       serial clock
//   MOSI       serial data to slave
//   SS_N       active-low slave selects, at most one low
module spi_master_param #(
  parameter int W    = 15,
  parameter int DIV  = 4,
  parameter int N_SS = 4,
  parameter int SSW  = 2
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            st,
  input  logic            abort,
  input  logic [1:0]      mode,
  input  logic            lsb_first,
  input  logic [SSW-1:0]  ss_sel,
  input  logic [W-1:0]    DI,
  input  logic            MISO,
  output logic [W-1:0]    DO,
  output logic            busy,
  output logic            done,
  output logic            LOAD,
  output logic            SCLK,
  output logic            MOSI,
  output logic [N_SS-1:0] SS_N
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int EW = $clog2(2 * W + 1);

  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_XFER, S_TRAIL, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [EW-1:0]   ecnt_q, ecnt_d;
  logic [W-1:0]    tx_q, tx_d;
  logic [W-1:0]    rx_q, rx_d;
  logic [W-1:0]    do_q, do_d;
  logic            cpol_q, cpol_d;
  logic            cpha_q, cpha_d;
  logic            lsb_q, lsb_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            load_q, load_d;
  logic            sclk_q, sclk_d;
  logic            mosi_q, mosi_d;
  logic [N_SS-1:0] ss_n_q, ss_n_d;

  logic          half_end, in_frame, odd_edge, do_sample, do_shift;
  logic [EW-1:0] ecnt_n;

  function automatic logic head_bit(input logic [W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[W-1];
  endfunction

  function automatic logic [W-1:0] shift_tx(input logic [W-1:0] v, input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  // An index with no matching line leaves every select high.
  function automatic logic [N_SS-1:0] ss_decode(input logic [SSW-1:0] idx);
    logic [N_SS-1:0] r;
    r = '1;
    for (int i = 0; i < N_SS; i++)
      if (int'(idx) == i) r[i] = 1'b0;
    return r;
  endfunction

  assign half_end = (cnt_q == CW'(DIV - 1));
  assign in_frame = (state_q == S_LEAD) || (state_q == S_XFER) || (state_q == S_TRAIL);
  assign ecnt_n   = ecnt_q + EW'(1);
  assign odd_edge = ecnt_n[0];
  // CPHA=0 samples on odd edges and shifts on even ones (except the last);
  // CPHA=1 shifts on odd edges and samples on even ones.
  assign do_sample = cpha_q ? ~odd_edge : odd_edge;
  assign do_shift  = cpha_q ? odd_edge : (~odd_edge && (ecnt_n != EW'(2 * W)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ecnt_d  = ecnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    do_d    = do_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    lsb_d   = lsb_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load_d  = load_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    ss_n_d  = ss_n_q;

    if (in_frame) cnt_d = half_end ? '0 : cnt_q + CW'(1);

    if (st && ((state_q == S_IDLE) || (state_q == S_DONE))) begin
      state_d = S_LEAD;
      cnt_d   = '0;
      ecnt_d  = '0;
      cpol_d  = mode[1];
      cpha_d  = mode[0];
      lsb_d   = lsb_first;
      rx_d    = '0;
      busy_d  = 1'b1;
      load_d  = 1'b1;
      sclk_d  = mode[1];
      ss_n_d  = ss_decode(ss_sel);
      // CPHA=0 needs the first bit valid before the first (sampling) edge.
      if (!mode[0]) begin
        mosi_d = head_bit(DI, lsb_first);
        tx_d   = shift_tx(DI, lsb_first);
      end else begin
        tx_d = DI;
      end
    end else if (abort && in_frame) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      ecnt_d  = '0;
      busy_d  = 1'b0;
      load_d  = 1'b0;
      sclk_d  = cpol_q;
      ss_n_d  = '1;
    end else begin
      case (state_q)
        S_LEAD: if (half_end) state_d = S_XFER;
        S_XFER: begin
          if (half_end) begin
            sclk_d = ~sclk_q;
            ecnt_d = ecnt_n;
            if (do_sample) rx_d = lsb_q ? {MISO, rx_q[W-1:1]} : {rx_q[W-2:0], MISO};
            if (do_shift) begin
              mosi_d = head_bit(tx_q, lsb_q);
              tx_d   = shift_tx(tx_q, lsb_q);
            end
            if (ecnt_n == EW'(2 * W)) state_d = S_TRAIL;
          end
        end
        S_TRAIL: begin
          if (half_end) begin
            state_d = S_DONE;
            do_d    = rx_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            load_d  = 1'b0;
            ss_n_d  = '1;
          end
        end
        S_DONE: state_d = S_IDLE;
        default: begin
          busy_d = 1'b0;
          load_d = 1'b0;
          ss_n_d = '1;
          sclk_d = cpol_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ecnt_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      do_q    <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      load_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ss_n_q  <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ecnt_q  <= ecnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      do_q    <= do_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      lsb_q   <= lsb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      load_q  <= load_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      ss_n_q  <= ss_n_d;
    end
  end

  assign DO   = do_q;
  assign busy = busy_q;
  assign done = done_q;
  assign LOAD = load_q;
  assign SCLK = sclk_q;
  assign MOSI = mosi_q;
  assign SS_N = ss_n_q;

endmodule

// File: tb/tb_spi_master_param.sv
// tb/tb_spi_master_param.sv - scoreboard testbench for spi_master_param
module tb_spi_master_param;
  localparam int W     = 15;
  localparam int DIV   = 2;
  localparam int N_SS  = 4;
  localparam int SSW   = 2;
  localparam int FRAME = (2 * W + 2) * DIV;

  logic            clk = 1'b0;
  logic            clr = 1'b0;
  logic            st = 1'b0;
  logic            abort = 1'b0;
  logic [1:0]      mode = 2'd0;
  logic            lsb_first = 1'b0;
  logic [SSW-1:0]  ss_sel = '0;
  logic [W-1:0]    DI = '0;
  logic            MISO;
  logic [W-1:0]    DO;
  logic            busy, done, LOAD, SCLK, MOSI;
  logic [N_SS-1:0] SS_N;

  spi_master_param #(.W(W), .DIV(DIV), .N_SS(N_SS), .SSW(SSW)) dut (
    .clk(clk), .clr(clr), .st(st), .abort(abort), .mode(mode),
    .lsb_first(lsb_first), .ss_sel(ss_sel), .DI(DI), .MISO(MISO),
    .DO(DO), .busy(busy), .done(done), .LOAD(LOAD), .SCLK(SCLK),
    .MOSI(MOSI), .SS_N(SS_N)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]    exp_do;
    logic [W-1:0]    exp_srx;
    int              exp_cyc;
    logic [N_SS-1:0] exp_ss;
    logic            cpol;
  } exp_t;

  exp_t sbq[$];

  int n_chk = 0, n_pass = 0, cyc = 0, done_cnt = 0;

  bit           loopback = 1'b1;
  logic [1:0]   cur_mode = 2'd0;
  logic [W-1:0] slv_word = '0;
  logic         slv_miso = 1'b0;
  int           tog = 0;
  logic         sclk_prev = 1'b0, mosi_prev = 1'b0, ss_low_prev = 1'b0;
  logic [W-1:0] srx = '0;
  int           ss_low_cnt = 0;
  bit           ss_bad = 1'b0, mosi_bad = 1'b0;

  assign MISO = loopback ? MOSI : slv_miso;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  always @(posedge clk) cyc++;

  // Monitor: pops the scoreboard on every done pulse, and acts as the slave
  // (serves slv_word on MISO, captures MOSI at the sampling edges).
  always @(negedge clk) begin : monitor
    bit   ss_low_now, sclk_moved, samp_lvl;
    int   idx;
    exp_t e;
    if (done) begin
      done_cnt++;
      if (sbq.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = sbq.pop_front();
        chk("DO", DO, e.exp_do);
        chk("slave_rx", srx, e.exp_srx);
        chk("done_cycle", cyc, e.exp_cyc);
        chk("ss_low_cycles", ss_low_cnt, FRAME);
        chk("ss_pattern_bad", ss_bad, 0);
        chk("mosi_on_sample_edge", mosi_bad, 0);
        chk("sclk_idle_at_done", SCLK, e.cpol);
      end
    end
    ss_low_now = (SS_N != '1);
    sclk_moved = (SCLK != sclk_prev) && ss_low_now && ss_low_prev;
    samp_lvl   = cur_mode[0] ? (SCLK == cur_mode[1]) : (SCLK != cur_mode[1]);
    if (!busy) begin
      tog = 0; srx = '0; ss_low_cnt = 0; ss_bad = 1'b0; mosi_bad = 1'b0;
    end else begin
      if (ss_low_now) begin
        ss_low_cnt++;
        if (sbq.size() > 0 && SS_N !== sbq[0].exp_ss) ss_bad = 1'b1;
      end
      if (sclk_moved) begin
        tog++;
        if (samp_lvl) begin
          srx = {srx[W-2:0], MOSI};
          if (MOSI != mosi_prev) mosi_bad = 1'b1;
        end
      end
    end
    idx = cur_mode[0] ? ((tog > 0) ? (tog - 1) / 2 : 0) : tog / 2;
    slv_miso    = (idx < W) ? slv_word[W-1-idx] : 1'b0;
    sclk_prev   = SCLK;
    mosi_prev   = MOSI;
    ss_low_prev = ss_low_now;
  end

  // Called at a negedge; returns at the negedge of the first LEAD cycle,
  // after scrambling the latched inputs to show they are ignored mid-frame.
  task automatic start_frame(input logic [W-1:0] di, input logic [1:0] m, input logic lsb,
                             input logic [SSW-1:0] ss, input bit lb, input logic [W-1:0] sword,
                             input bit push, input logic [W-1:0] exp_do,
                             input logic [W-1:0] exp_srx, input logic [N_SS-1:0] exp_ss);
    exp_t e;
    DI = di; mode = m; lsb_first = lsb; ss_sel = ss;
    loopback = lb; slv_word = sword; cur_mode = m; st = 1'b1;
    if (push) begin
      e.exp_do = exp_do; e.exp_srx = exp_srx; e.exp_cyc = cyc + 1 + FRAME;
      e.exp_ss = exp_ss; e.cpol = m[1];
      sbq.push_back(e);
    end
    @(negedge clk);
    st = 1'b0; DI = ~di; mode = ~m; lsb_first = ~lsb; ss_sel = ss + 1'b1;
  endtask

  task automatic wait_done(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < FRAME + 20 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    chk(name, got, 1);
  endtask

  task automatic wait_tog(input string name, input int n);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < FRAME + 20 && !hit; i++) begin
      @(negedge clk);
      if (tog >= n) hit = 1'b1;
    end
    chk(name, hit, 1);
  endtask

  initial begin : stim
    exp_t e;
    int   cnt0;
    repeat (3) @(negedge clk);
    chk("rst_DO", DO, 0);       chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_LOAD", LOAD, 0);   chk("rst_SCLK", SCLK, 0); chk("rst_MOSI", MOSI, 0);
    chk("rst_SS_N", SS_N, 4'hF);
    clr = 1'b1;
    @(negedge clk);

    // loopback, mode 0, MSB first, slave 1
    start_frame(15'h5A3C, 2'd0, 1'b0, 2'd1, 1'b1, '0, 1'b1, 15'h5A3C, 15'h5A3C, 4'b1101);
    wait_done("done_loopback");
    @(negedge clk);
    chk("idle_sclk_m0", SCLK, 0);

    // all four modes against a slave returning 0x1234
    for (int m = 0; m < 4; m++) begin
      start_frame(15'h7FFF, 2'(m), 1'b0, 2'd2, 1'b0, 15'h1234, 1'b1, 15'h1234, 15'h7FFF, 4'b1011);
      wait_done("done_mode");
      @(negedge clk);
      chk("idle_sclk_mode", SCLK, m[1]);
      chk("idle_busy_mode", busy, 0);
    end

    // LSB first: slave sees 1 then fourteen 0s
    start_frame(15'h0001, 2'd0, 1'b1, 2'd0, 1'b1, '0, 1'b1, 15'h0001, 15'h4000, 4'b1110);
    wait_done("done_lsb");
    @(negedge clk);

    // back-to-back with st held high
    DI = 15'h0AAA; mode = 2'd0; lsb_first = 1'b0; ss_sel = 2'd0;
    loopback = 1'b1; cur_mode = 2'd0; st = 1'b1;
    e.exp_do = 15'h0AAA; e.exp_srx = 15'h0AAA; e.exp_cyc = cyc + 1 + FRAME;
    e.exp_ss = 4'b1110; e.cpol = 1'b0;
    sbq.push_back(e);
    e.exp_do = 15'h1555; e.exp_srx = 15'h1555; e.exp_cyc = cyc + 1 + FRAME + 1 + FRAME;
    sbq.push_back(e);
    @(negedge clk);
    DI = 15'h1555;
    wait_done("done_b2b_1");
    chk("b2b_ss_high_in_done", SS_N, 4'hF);
    @(negedge clk);
    st = 1'b0;
    chk("b2b_ss_low_again", SS_N, 4'b1110);
    chk("b2b_busy_again", busy, 1);
    wait_done("done_b2b_2");
    @(negedge clk);

    // establish DO = 0x0F0F, then abort a frame after edge 10
    start_frame(15'h0F0F, 2'd0, 1'b0, 2'd0, 1'b1, '0, 1'b1, 15'h0F0F, 15'h0F0F, 4'b1110);
    wait_done("done_0f0f");
    @(negedge clk);
    start_frame(15'h7777, 2'd0, 1'b0, 2'd2, 1'b1, '0, 1'b0, '0, '0, '0);
    wait_tog("abort_reach_edge10", 10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);     chk("abort_ss_n", SS_N, 4'hF);
    chk("abort_load", LOAD, 0);     chk("abort_do_kept", DO, 15'h0F0F);
    chk("abort_sclk", SCLK, 0);
    cnt0 = done_cnt;
    repeat (FRAME + 10) @(negedge clk);
    chk("abort_no_done", done_cnt, cnt0);

    // abort together with st in IDLE: the start wins
    abort = 1'b1;
    start_frame(15'h3333, 2'd1, 1'b0, 2'd3, 1'b1, '0, 1'b1, 15'h3333, 15'h3333, 4'b0111);
    abort = 1'b0;
    wait_done("done_abort_st");
    @(negedge clk);

    // reset in the middle of XFER
    start_frame(15'h2222, 2'd0, 1'b0, 2'd1, 1'b1, '0, 1'b0, '0, '0, '0);
    wait_tog("reset_reach_edge5", 5);
    clr = 1'b0;
    #1;
    chk("midrst_DO", DO, 0);       chk("midrst_busy", busy, 0); chk("midrst_done", done, 0);
    chk("midrst_LOAD", LOAD, 0);   chk("midrst_SCLK", SCLK, 0); chk("midrst_MOSI", MOSI, 0);
    chk("midrst_SS_N", SS_N, 4'hF);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    start_frame(15'h6B5D, 2'd3, 1'b0, 2'd1, 1'b1, '0, 1'b1, 15'h6B5D, 15'h6B5D, 4'b1101);
    wait_done("done_after_reset");
    @(negedge clk);

    chk("scoreboard_empty", sbq.size(), 0);
    chk("total_done_pulses", done_cnt, 11);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
